vstu_b_tracker: RTL and testbench
=================================

Name: vstu_b_tracker

Overview:
- Downstream companion of the vector store unit on the AXI write path.
- Records one entry per accepted AW burst: owning vector instruction ID, plus a flag marking the instruction's final burst.
- Retires entries in order as B responses arrive. Raises store completion and the sequencer's vinsn_done bit only after the last burst of an instruction is acknowledged.
- Accumulates non-OKAY responses per instruction and reports them once.

Parameters:
- NrVInsn, 8, number of vector instruction IDs; ID width is idx_width(NrVInsn).
- MaxOutstanding, 8, tracker FIFO depth (outstanding AW bursts); any value >= 2, not restricted to powers of two.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- aw_valid_i  in  1  an AW burst is being issued by the address generator
- aw_ready_o  out  1  tracker can record the burst (not full)
- aw_vinsn_id_i  in  idx_width(NrVInsn)  instruction owning the burst
- aw_last_burst_i  in  1  burst is the final one of its instruction
- b_valid_i  in  1  AXI B valid
- b_ready_o  out  1  AXI B ready
- b_resp_i  in  2  AXI B resp
- store_complete_o  out  1  one-cycle pulse: an instruction's stores are fully acknowledged
- vinsn_done_o  out  NrVInsn  one-hot pulse, ID of the completed instruction
- store_error_o  out  1  pulse with store_complete_o when any burst of that instruction returned SLVERR/DECERR
- outstanding_o  out  idx_width(MaxOutstanding)+1  bursts in flight
- empty_o  out  1  no bursts in flight

Behaviour:
- Storage
  - Circular FIFO of {id, last} records, MaxOutstanding entries.
  - Write and read pointers wrap explicitly to 0 after MaxOutstanding-1.
  - Occupancy counter cnt_q ranges 0..MaxOutstanding; outstanding_o = cnt_q.
- AW side
  - aw_ready_o = (cnt_q != MaxOutstanding), combinational from state only.
  - Push on aw_valid_i && aw_ready_o.
  - When full, no push even if a pop happens in the same cycle (no bypass).
- B side
  - b_ready_o = (cnt_q != 0).
  - A B beat arriving while empty is a protocol violation: it is not acknowledged, and the bench asserts on it.
  - Pop on b_valid_i && b_ready_o.
- Simultaneous push and pop: pointers both advance; cnt_q is unchanged.
- Error accumulation
  - err_acc_q is set when a popped beat has b_resp_i[1] == 1 (SLVERR or DECERR).
  - On a pop whose entry has last == 1, err_acc_q is cleared in the same cycle.
  - EXOKAY is treated as OKAY.
- Completion
  - Registered outputs, asserted the cycle after a pop of a last == 1 entry:
    - store_complete_o = 1
    - vinsn_done_o[id] = 1, all other bits 0
    - store_error_o = err_acc_q | (b_resp_i[1] at that pop)
  - Pulses last exactly one cycle.
  - Back-to-back last pops yield back-to-back pulses.
  - Non-last pops produce no output pulse.
- Latency: AW record to earliest completion pulse = 2 cycles (push at cycle t, B pop at t+1, pulse at t+2).
- Ordering: responses are in order (single AXI ID). The tracker never reorders or matches by ID.
- Reset, asynchronous, including mid-operation:
  - Pointers, cnt_q, err_acc_q and all registered outputs go to 0.
  - aw_ready_o = 1, b_ready_o = 0, empty_o = 1.
  - In-flight records are discarded; no completion pulses after reset.

Decomposition:
- ara_pkg holds:
  - the record typedef b_track_entry_t {vinsn_id, last_burst}
  - the extension of addrgen_axi_req_t with a last_burst field that drives aw_last_burst_i
- Sub-module: b_track_fifo (generic circular FIFO with explicit wrap, count output, full/empty).
- The top holds the error accumulator and the completion output registers.
- The vector store unit's B-channel handling is replaced by this block's store_complete_o and vinsn_done_o.

Test Plan:
- Single burst, OKAY:
  - Stimulus: push id=3, last=1; B OKAY next cycle.
  - Response: store_complete_o and vinsn_done_o=8'b0000_1000 for exactly one cycle, 2 cycles after push; store_error_o=0; empty_o=1 afterwards.
- Multi-burst instruction:
  - Stimulus: push id=1 with last=0,0,1; three OKAY B beats.
  - Response: no pulse after beats 1 and 2; pulse vinsn_done_o[1] after beat 3.
- Error accumulation:
  - Stimulus: id=2, 3 bursts; B resp = OKAY, SLVERR, OKAY.
  - Response: store_error_o=1 with completion for id 2.
  - Stimulus: following id=4, 1 burst, OKAY.
  - Response: store_error_o=0, proving the accumulator was cleared.
- Full and wrap:
  - Stimulus: 8 pushes with no B.
  - Response: outstanding_o=8, aw_ready_o=0.
  - Stimulus: a push attempt while full, coincident with a B pop.
  - Response: the push is not accepted; outstanding_o=7.
  - Stimulus: 20 further push/pop pairs.
  - Response: pointers wrap, and IDs retire in issue order.
- Simultaneous push/pop at cnt=3:
  - Response: outstanding_o stays 3.
  - Stimulus: interleaved last entries for ids 5 then 6.
  - Response: back-to-back pulses, 5 then 6.
- Reset mid-operation:
  - Stimulus: assert rst_ni low with 4 bursts outstanding and err_acc set.
  - Response: all outputs 0, aw_ready_o=1, b_ready_o=0; a B beat after release is not acknowledged.

Source files
------------

// File: rtl/ara_pkg.sv
// Shared types for the vector store path.
// Holds the B-tracker record and the address-generator request with its final-burst flag.
package ara_pkg;

  localparam int unsigned DefNrVInsn   = 8;
  localparam int unsigned AxiAddrWidth = 64;

  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 1) ? unsigned'($clog2(num_idx)) : 1;
  endfunction

  typedef logic [idx_width(DefNrVInsn)-1:0] vid_t;

  typedef struct packed {
    vid_t vinsn_id;
    logic last_burst;
  } b_track_entry_t;

  // The last_burst field drives aw_last_burst_i of the B tracker.
  typedef struct packed {
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    is_load;
    vid_t                    vinsn_id;
    logic                    last_burst;
  } addrgen_axi_req_t;

endpackage

// File: rtl/b_track_fifo.sv
// Circular FIFO with explicit pointer wrap, so any depth >= 2 works.
// Full writes are dropped even when a pop happens in the same cycle.
module b_track_fifo
  import ara_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic [Width-1:0]          wdata_i,
  output logic [Width-1:0]          rdata_o,
  output logic [idx_width(Depth):0] cnt_o,
  output logic                      full_o,
  output logic                      empty_o
);

  localparam int unsigned PtrW = idx_width(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == FullCnt);
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign rdata_o = mem_q[rptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok) wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
    if (pop_ok)  rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Payload needs no reset: it is only read while cnt_q says it is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/vstu_b_tracker.sv
// Tracks outstanding AXI write bursts of the vector store unit and retires them on B responses,
// signalling per-instruction completion (and any accumulated error) after the final burst.
module vstu_b_tracker
  import ara_pkg::*;
#(
  parameter int unsigned NrVInsn        = DefNrVInsn,
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               aw_valid_i,
  output logic                               aw_ready_o,
  input  logic [idx_width(NrVInsn)-1:0]      aw_vinsn_id_i,
  input  logic                               aw_last_burst_i,
  input  logic                               b_valid_i,
  output logic                               b_ready_o,
  input  logic [1:0]                         b_resp_i,
  output logic                               store_complete_o,
  output logic [NrVInsn-1:0]                 vinsn_done_o,
  output logic                               store_error_o,
  output logic [idx_width(MaxOutstanding):0] outstanding_o,
  output logic                               empty_o
);

  localparam int unsigned IdW = idx_width(NrVInsn);

  logic           full, empty, push, pop;
  logic [IdW:0]   wdata, rdata;
  logic [IdW-1:0] pop_id;
  logic           pop_last, resp_err;
  logic           unused_resp_exokay;

  assign aw_ready_o = ~full;
  assign b_ready_o  = ~empty;
  assign empty_o    = empty;
  assign push       = aw_valid_i & aw_ready_o;
  assign pop        = b_valid_i & b_ready_o;
  assign wdata      = {aw_vinsn_id_i, aw_last_burst_i};
  assign {pop_id, pop_last} = rdata;
  // Only resp[1] distinguishes SLVERR/DECERR; EXOKAY counts as OKAY.
  assign resp_err           = b_resp_i[1];
  assign unused_resp_exokay = b_resp_i[0];

  b_track_fifo #(
    .Depth(MaxOutstanding),
    .Width(IdW + 1)
  ) i_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i(wdata),
    .rdata_o(rdata),
    .cnt_o  (outstanding_o),
    .full_o (full),
    .empty_o(empty)
  );

  logic               err_acc_q, err_acc_d;
  logic               complete_q, complete_d;
  logic               error_q, error_d;
  logic [NrVInsn-1:0] done_q, done_d;

  always_comb begin
    err_acc_d  = err_acc_q;
    complete_d = 1'b0;
    error_d    = 1'b0;
    done_d     = '0;
    if (pop) begin
      if (pop_last) begin
        err_acc_d      = 1'b0;
        complete_d     = 1'b1;
        error_d        = err_acc_q | resp_err;
        done_d[pop_id] = 1'b1;
      end else begin
        err_acc_d = err_acc_q | resp_err;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_acc_q  <= 1'b0;
      complete_q <= 1'b0;
      error_q    <= 1'b0;
      done_q     <= '0;
    end else begin
      err_acc_q  <= err_acc_d;
      complete_q <= complete_d;
      error_q    <= error_d;
      done_q     <= done_d;
    end
  end

  assign store_complete_o = complete_q;
  assign store_error_o    = error_q;
  assign vinsn_done_o     = done_q;

endmodule

// File: tb/tb_vstu_b_tracker.sv
// Self-checking bench for vstu_b_tracker: directed scenarios plus randomized traffic
// against a queue-based model of outstanding bursts and per-instruction error flags.
module tb_vstu_b_tracker;

  localparam int unsigned NrV  = 8;
  localparam int unsigned MaxO = 8;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       aw_valid, aw_last, b_valid;
  logic [2:0] aw_id;
  logic [1:0] b_resp;
  logic       aw_ready_o, b_ready_o, store_complete_o, store_error_o, empty_o;
  logic [7:0] vinsn_done_o;
  logic [3:0] outstanding_o;

  vstu_b_tracker #(
    .NrVInsn(NrV),
    .MaxOutstanding(MaxO)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .aw_valid_i      (aw_valid),
    .aw_ready_o      (aw_ready_o),
    .aw_vinsn_id_i   (aw_id),
    .aw_last_burst_i (aw_last),
    .b_valid_i       (b_valid),
    .b_ready_o       (b_ready_o),
    .b_resp_i        (b_resp),
    .store_complete_o(store_complete_o),
    .vinsn_done_o    (vinsn_done_o),
    .store_error_o   (store_error_o),
    .outstanding_o   (outstanding_o),
    .empty_o         (empty_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned id;
    bit          last;
  } ent_t;

  ent_t mq[$];
  bit   err_of[NrV];
  int   checks = 0;
  int   errors = 0;
  logic       exp_complete, exp_err;
  logic [7:0] exp_done;

  // Drives one cycle of stimulus from a negedge and returns at the next negedge.
  // The model is updated from the rules: bursts leave in issue order, an instruction's
  // error is the OR of all its responses, and it is reported when its last burst retires.
  task automatic step(input bit av, input int unsigned id, input bit lst, input bit bv,
                      input logic [1:0] rsp);
    bit   acc_push, acc_pop;
    ent_t e;
    aw_valid = av; aw_id = id[2:0]; aw_last = lst; b_valid = bv; b_resp = rsp;
    acc_push = av && (mq.size() < MaxO);
    acc_pop  = bv && (mq.size() > 0);
    exp_complete = 1'b0; exp_err = 1'b0; exp_done = '0;
    if (acc_pop) begin
      e = mq.pop_front();
      if (rsp == 2'b10 || rsp == 2'b11) err_of[e.id] = 1'b1;
      if (e.last) begin
        exp_complete   = 1'b1;
        exp_done[e.id] = 1'b1;
        exp_err        = err_of[e.id];
        err_of[e.id]   = 1'b0;
      end
    end
    if (acc_push) begin
      e.id = id; e.last = lst;
      mq.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    aw_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * MaxO && mq.size() > 0; i++) step(0, 0, 0, 1, 2'b00);
    step(0, 0, 0, 0, 2'b00);
  endtask

  task automatic test_reset();
    checks++;
    if ({aw_ready_o, b_ready_o, empty_o, outstanding_o} !== {3'b101, 4'd0}) begin
      errors++;
      $display("FAIL reset_ready got aw_rdy=%b b_rdy=%b empty=%b out=%0d want 1 0 1 0",
               aw_ready_o, b_ready_o, empty_o, outstanding_o);
    end
    checks++;
    if ({store_complete_o, store_error_o, vinsn_done_o} !== 10'd0) begin
      errors++;
      $display("FAIL reset_pulses got cmp=%b err=%b done=%b want 0", store_complete_o,
               store_error_o, vinsn_done_o);
    end
  endtask

  task automatic test_single();
    step(1, 3, 1, 0, 2'b00);
    checks++;
    if (store_complete_o !== 1'b0 || outstanding_o !== 4'd1) begin
      errors++;
      $display("FAIL single_push got cmp=%b out=%0d want 0 1", store_complete_o, outstanding_o);
    end
    step(0, 0, 0, 1, 2'b00);
    checks++;
    if ({store_complete_o, vinsn_done_o, store_error_o} !== {1'b1, 8'b0000_1000, 1'b0}) begin
      errors++;
      $display("FAIL single_pulse got cmp=%b done=%b err=%b want 1 00001000 0",
               store_complete_o, vinsn_done_o, store_error_o);
    end
    step(0, 0, 0, 0, 2'b00);
    checks++;
    if (store_complete_o !== 1'b0 || vinsn_done_o !== 8'd0 || empty_o !== 1'b1) begin
      errors++;
      $display("FAIL single_after got cmp=%b done=%b empty=%b want 0 0 1", store_complete_o,
               vinsn_done_o, empty_o);
    end
  endtask

  task automatic test_multi();
    bit lasts[3] = '{0, 0, 1};
    foreach (lasts[i]) step(1, 1, lasts[i], 0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 2'b00);
      checks++;
      if (store_complete_o !== (i == 2) || vinsn_done_o !== ((i == 2) ? 8'b10 : 8'b0)) begin
        errors++;
        $display("FAIL multi_beat%0d got cmp=%b done=%b want %b %b", i, store_complete_o,
                 vinsn_done_o, (i == 2), (i == 2) ? 8'b10 : 8'b0);
      end
    end
  endtask

  task automatic test_error();
    logic [1:0] rsps[3] = '{2'b00, 2'b10, 2'b00};
    step(1, 2, 0, 0, 2'b00);
    step(1, 2, 0, 0, 2'b00);
    step(1, 2, 1, 0, 2'b00);
    step(1, 4, 1, 0, 2'b00);
    foreach (rsps[i]) step(0, 0, 0, 1, rsps[i]);
    checks++;
    if ({store_complete_o, vinsn_done_o, store_error_o} !== {1'b1, 8'b0000_0100, 1'b1}) begin
      errors++;
      $display("FAIL error_id2 got cmp=%b done=%b err=%b want 1 00000100 1", store_complete_o,
               vinsn_done_o, store_error_o);
    end
    step(0, 0, 0, 1, 2'b00);
    checks++;
    if ({store_complete_o, vinsn_done_o, store_error_o} !== {1'b1, 8'b0001_0000, 1'b0}) begin
      errors++;
      $display("FAIL error_cleared got cmp=%b done=%b err=%b want 1 00010000 0",
               store_complete_o, vinsn_done_o, store_error_o);
    end
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 8; i++) step(1, i, 1, 0, 2'b00);
    checks++;
    if (outstanding_o !== 4'd8 || aw_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL full got out=%0d aw_rdy=%b want 8 0", outstanding_o, aw_ready_o);
    end
    step(1, 5, 1, 1, 2'b00);
    checks++;
    if (outstanding_o !== 4'd7 || vinsn_done_o !== 8'b0000_0001) begin
      errors++;
      $display("FAIL full_no_bypass got out=%0d done=%b want 7 00000001", outstanding_o,
               vinsn_done_o);
    end
    for (int k = 0; k < 20; k++) begin
      step(1, k % 8, 1, 1, 2'b00);
      checks++;
      if (vinsn_done_o !== exp_done || store_complete_o !== exp_complete ||
          outstanding_o !== 4'd7) begin
        errors++;
        $display("FAIL wrap_pair%0d got done=%b cmp=%b out=%0d want %b %b 7", k, vinsn_done_o,
                 store_complete_o, outstanding_o, exp_done, exp_complete);
      end
    end
    drain();
  endtask

  task automatic test_simul();
    step(1, 5, 0, 0, 2'b00);
    step(1, 5, 1, 0, 2'b00);
    step(1, 6, 1, 0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 1, 2'b00);
      checks++;
      if (outstanding_o !== 4'd3) begin
        errors++;
        $display("FAIL simul_cnt%0d got out=%0d want 3", i, outstanding_o);
      end
      checks++;
      if (vinsn_done_o !== ((i == 0) ? 8'h00 : (i == 1) ? 8'h20 : 8'h40)) begin
        errors++;
        $display("FAIL simul_pulse%0d got done=%b want %b", i, vinsn_done_o,
                 (i == 0) ? 8'h00 : (i == 1) ? 8'h20 : 8'h40);
      end
    end
    drain();
  endtask

  task automatic test_random();
    int unsigned cur_id = 0;
    bit av, lst, bv;
    for (int n = 0; n < 400; n++) begin
      av  = ($urandom_range(0, 1) == 1);
      lst = ($urandom_range(0, 2) == 0);
      bv  = ($urandom_range(0, 1) == 1) && (mq.size() > 0);
      step(av, cur_id, lst, bv, 2'($urandom_range(0, 3)));
      if (av && lst && mq.size() > 0 && mq[$].last) cur_id = $urandom_range(0, 7);
      checks++;
      if (store_complete_o !== exp_complete || vinsn_done_o !== exp_done ||
          store_error_o !== exp_err) begin
        errors++;
        $display("FAIL rand_pulse%0d got cmp=%b done=%b err=%b want %b %b %b", n,
                 store_complete_o, vinsn_done_o, store_error_o, exp_complete, exp_done, exp_err);
      end
      checks++;
      if (outstanding_o !== 4'(mq.size()) || empty_o !== (mq.size() == 0) ||
          aw_ready_o !== (mq.size() < MaxO) || b_ready_o !== (mq.size() > 0)) begin
        errors++;
        $display("FAIL rand_state%0d got out=%0d empty=%b aw=%b b=%b want out=%0d", n,
                 outstanding_o, empty_o, aw_ready_o, b_ready_o, mq.size());
      end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1, 7, 0, 0, 2'b00);
    step(0, 0, 0, 1, 2'b10);
    step(1, 7, 1, 1, 2'b00);
    #2 rst_ni = 1'b0;
    #1;
    mq.delete();
    foreach (err_of[i]) err_of[i] = 1'b0;
    checks++;
    if ({aw_ready_o, b_ready_o, empty_o, outstanding_o, store_complete_o, store_error_o,
         vinsn_done_o} !== {3'b101, 4'd0, 10'd0}) begin
      errors++;
      $display("FAIL reset_mid got aw=%b b=%b empty=%b out=%0d cmp=%b err=%b done=%b",
               aw_ready_o, b_ready_o, empty_o, outstanding_o, store_complete_o, store_error_o,
               vinsn_done_o);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    b_valid = 1'b1;
    #1;
    checks++;
    if (b_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL stray_b_ack got b_ready=%b want 0", b_ready_o);
    end
    step(0, 0, 0, 1, 2'b00);
    checks++;
    if (store_complete_o !== 1'b0 || vinsn_done_o !== 8'd0 || outstanding_o !== 4'd0) begin
      errors++;
      $display("FAIL post_reset got cmp=%b done=%b out=%0d want 0 0 0", store_complete_o,
               vinsn_done_o, outstanding_o);
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    aw_valid = 1'b0; aw_id = '0; aw_last = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
    repeat (3) @(negedge clk);
    test_reset();
    rst_ni = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_multi();
    test_error();
    test_full_wrap();
    test_simul();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
